// File: rtl/conv1.sv
// conv1: streaming 3x3 convolution over a raster-order frame.
// Two line buffers feed a sliding window; a result is registered one clock
// after the pixel that completes a fully in-frame 3x3 window.

// One kernel tap: signed 16x8 product, sign-extended to the accumulator width.
module conv1_tap (
    input  logic [15:0] pix,
    input  logic [7:0]  coef,
    output logic [31:0] prod
);
    logic signed [23:0] p;
    assign p    = 24'(signed'(pix)) * 24'(signed'(coef));
    assign prod = 32'(p);
endmodule

module conv1 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter logic signed [7:0] K00 = 8'sd1,
    parameter logic signed [7:0] K01 = 8'sd2,
    parameter logic signed [7:0] K02 = 8'sd1,
    parameter logic signed [7:0] K10 = 8'sd0,
    parameter logic signed [7:0] K11 = 8'sd0,
    parameter logic signed [7:0] K12 = 8'sd0,
    parameter logic signed [7:0] K20 = -8'sd1,
    parameter logic signed [7:0] K21 = -8'sd2,
    parameter logic signed [7:0] K22 = -8'sd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic        rdata_r,
    output logic [31:0] data_out,
    output logic        wdata_r
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    // Tap k = i*3 + j, i = window row (0 oldest), j = window column (0 leftmost).
    localparam logic [8:0][7:0] KER = {K22, K21, K20, K12, K11, K10, K02, K01, K00};

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb0 holds the row two above the current one, lb1 the row directly above.
    logic [15:0] lb0 [IMG_W];
    logic [15:0] lb1 [IMG_W];

    // Two older window columns per row; the newest column comes straight
    // from the line buffers and the incoming pixel.
    logic [2:0][1:0][15:0] win;
    logic [2:0][15:0]      ncol;
    logic [8:0][15:0]      tap_pix;
    logic [8:0][31:0]      tap_prod;
    logic [31:0]           acc;

    assign ncol[0] = lb0[col];
    assign ncol[1] = lb1[col];
    assign ncol[2] = data_in;

    for (genvar k = 0; k < 9; k++) begin : g_tap
        if (k % 3 == 2) begin : g_new
            assign tap_pix[k] = ncol[k/3];
        end else begin : g_old
            assign tap_pix[k] = win[k/3][k%3];
        end
        conv1_tap u_tap (
            .pix  (tap_pix[k]),
            .coef (KER[k]),
            .prod (tap_prod[k])
        );
    end

    // Adder tree over the nine taps of the window being completed this cycle.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 9; k++) acc = acc + tap_prod[k];
    end

    // Line buffers and window shift only on accepted pixels; contents never cleared.
    always_ff @(posedge clk) begin
        if (!reset_n && rdata_r) begin
            lb0[col] <= lb1[col];
            lb1[col] <= data_in;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= ncol[i];
            end
        end
    end

    // Raster position tracking and registered result with one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            col      <= '0;
            row      <= '0;
            data_out <= '0;
            wdata_r  <= 1'b0;
        end else begin
            wdata_r <= 1'b0;
            if (rdata_r) begin
                if (row >= RW'(2) && col >= CW'(2)) begin
                    data_out <= acc;
                    wdata_r  <= 1'b1;
                end
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv1.sv
// Bench for conv1: directed frames plus randomized pixels/stalls, checked
// cycle by cycle against a frame-array reference model (default kernel and
// an all-ones kernel instance driven with identical stimulus).
module tb_conv1;
    localparam int W = 28;
    localparam int H = 28;
    localparam int NRES = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data_in;
    logic        rdata_r;
    logic [31:0] data_out0, data_out1;
    logic        wdata_r0, wdata_r1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv1 #(.IMG_W(W), .IMG_H(H)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .rdata_r(rdata_r),
        .data_out(data_out0), .wdata_r(wdata_r0)
    );

    conv1 #(.IMG_W(W), .IMG_H(H),
            .K00(8'sd1), .K01(8'sd1), .K02(8'sd1),
            .K10(8'sd1), .K11(8'sd1), .K12(8'sd1),
            .K20(8'sd1), .K21(8'sd1), .K22(8'sd1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .rdata_r(rdata_r),
        .data_out(data_out1), .wdata_r(wdata_r1)
    );

    // Reference model state: the frame as an array, raster position, last outputs.
    int          img [H][W];
    int          mr, mc;
    logic [31:0] last0, last1;
    int          acc_n, pulses, first_pulse, nonzero, bad;
    int          kdef [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    int          kone [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] conv(input int k [9], input int r, input int c);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(k[i*3+j]) * longint'(img[r-2+i][c-2+j]);
        return s[31:0];
    endfunction

    // One clock: drive inputs, predict, then check both DUTs just after the edge.
    task automatic step(input logic v, input logic [15:0] px);
        logic        ev;
        logic [31:0] e0, e1;
        ev = 1'b0; e0 = '0; e1 = '0;
        reset_n = 1'b0;
        rdata_r = v;
        data_in = px;
        if (v) begin
            img[mr][mc] = int'($signed(px));
            if (mr >= 2 && mc >= 2) begin
                ev = 1'b1;
                e0 = conv(kdef, mr, mc);
                e1 = conv(kone, mr, mc);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
            acc_n++;
        end
        @(posedge clk);
        #1;
        check("vld0", 32'(wdata_r0), 32'(ev));
        check("vld1", 32'(wdata_r1), 32'(ev));
        if (ev) begin
            last0 = e0;
            last1 = e1;
        end
        check("out0", data_out0, last0);
        check("out1", data_out1, last1);
        if (wdata_r0) begin
            pulses++;
            if (first_pulse < 0) first_pulse = acc_n;
            if (data_out0 != 0) nonzero++;
            if (data_out0 != 32'hFFFF_FFF8) bad++;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset_n = 1'b1;
            rdata_r = 1'($urandom);
            data_in = 16'($urandom);
            @(posedge clk);
            #1;
        end
        mr = 0; mc = 0; last0 = '0; last1 = '0;
        check("rst_out0", data_out0, 32'd0);
        check("rst_vld0", 32'(wdata_r0), 32'd0);
        check("rst_out1", data_out1, 32'd0);
        check("rst_vld1", 32'(wdata_r1), 32'd0);
    endtask

    function automatic logic [15:0] pixval(input int mode, input int r, input int c);
        case (mode)
            0: return 16'd5;
            1: return 16'(r);
            2: return (r == 5 && c == 5) ? 16'd100 : 16'd0;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Full frame; stall mode 0 = none, 1 = mid-row-10 and end-of-row stalls, 2 = random.
    task automatic frame(input int mode, input int smode);
        acc_n = 0; pulses = 0; first_pulse = -1; nonzero = 0; bad = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (smode == 1 && r == 10 && c == W / 2)
                    for (int s = 0; s < 3; s++) step(1'b0, 16'($urandom));
                if (smode == 2)
                    while ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom));
                step(1'b1, pixval(mode, r, c));
            end
            if (smode == 1) step(1'b0, 16'($urandom));
        end
        check("pulse_cnt", 32'(pulses), 32'(NRES));
    endtask

    initial begin
        reset_n = 1'b1; rdata_r = 1'b0; data_in = '0;
        mr = 0; mc = 0; last0 = '0; last1 = '0;
        acc_n = 0; pulses = 0; first_pulse = -1; nonzero = 0; bad = 0;

        do_reset(2);

        // Constant 5: Sobel-like default kernel sums to zero; first pulse after pixel 59.
        frame(0, 0);
        check("const_first", 32'(first_pulse), 32'd59);
        check("const_nz", 32'(nonzero), 32'd0);

        // Row-index ramp: every default result is -8.
        frame(1, 0);
        check("ramp_not_m8", 32'(bad), 32'd0);

        // Impulse of 100 at (5,5): six nonzero results.
        frame(2, 0);
        check("imp_nz", 32'(nonzero), 32'd6);

        // Ramp again with stalls: same values, no pulses during stalls.
        frame(1, 1);
        check("stall_not_m8", 32'(bad), 32'd0);

        // Abort a frame after 400 pixels, then a fresh all -32768 frame.
        for (int i = 0; i < 400; i++) step(1'b1, 16'($urandom));
        do_reset(1);
        frame(3, 0);
        check("neg_last1", data_out1, 32'hFFFB_8000);  // -294912
        check("neg_last0", data_out0, 32'd0);

        // Random pixels with random stalls, back-to-back frames without reset.
        frame(4, 2);
        frame(4, 2);

        // Random mid-frame abort then random frame.
        for (int i = 0; i < int'($urandom_range(1, 700)); i++)
            step(1'($urandom), 16'($urandom));
        do_reset(3);
        frame(4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv1.md
CONV1 -- requirements
Module: conv1

Interface
REQ-001 Parameter IMG_W, default 28, meaning pixels per row.
REQ-002 Parameter IMG_H, default 28, meaning rows per frame.
REQ-003 Parameters K00,K01,K02,K10,K11,K12,K20,K21,K22, signed 8-bit, defaults 1,2,1,0,0,0,-1,-2,-1; Kij is the coefficient for window row i (0 = oldest row) and column j (0 = leftmost).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 data_in  input  16  pixel sample, signed two's complement.
REQ-007 rdata_r  input  1  input valid; data_in is accepted on each rising edge where rdata_r=1.
REQ-008 data_out  output  32  signed convolution result, registered.
REQ-009 wdata_r  output  1  output valid; high for exactly one cycle per result.

Function
REQ-010 Pixels SHALL arrive in raster order (row-major, left to right), one per accepted cycle.
REQ-011 Internal column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on accepted cycles; col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1), both wrap to 0 and a new frame starts with no reset needed.
REQ-012 Two line buffers of IMG_W pixels each plus a 3x3 window register SHALL hold the last three rows; no buffer or window state changes while rdata_r=0.
REQ-013 When the accepted pixel has row>=2 and col>=2, the 3x3 window with bottom-right at (row,col) is complete; result = sum over i,j of Kij * P(row-2+i, col-2+j).
REQ-014 Arithmetic SHALL be signed: 16x8 products, 9-term sum at least 28 bits, sign-extended to 32 bits; no saturation or rounding.
REQ-015 Latency: data_out SHALL update and wdata_r SHALL be 1 in the cycle following the accepting edge of the completing pixel (one-clock latency).
REQ-016 Windows that would span a row boundary (col<2) or the first two rows (row<2) SHALL produce no output; one frame yields exactly (IMG_W-2)*(IMG_H-2) = 676 results.
REQ-017 When no result is produced in a cycle, wdata_r SHALL be 0 and data_out SHALL hold its last value.
REQ-018 Stalls (rdata_r=0 for any number of cycles, at any position) SHALL NOT change the sequence or values of results.
REQ-019 There is no output back-pressure; each result is presented for one cycle only.

Reset
REQ-020 While reset_n=1 at a rising edge: data_out <= 0, wdata_r <= 0, col <= 0, row <= 0; rdata_r is ignored in that cycle.
REQ-021 Line-buffer and window contents need not be cleared; they SHALL NOT affect any result because outputs are gated by REQ-016.
REQ-022 Reset mid-frame SHALL abort the frame; the next accepted pixel is treated as (0,0).

Verification
REQ-023 Reset for 2 cycles -> data_out=0 and wdata_r=0 in the cycle after reset.
REQ-024 Full frame of constant pixel 5, rdata_r held at 1, default kernel -> 676 pulses, every data_out=0; the first pulse occurs in the cycle after the 59th accepted pixel, at position (2,2).
REQ-025 Full frame with pixel value = row index (0..27), default kernel -> 676 results, each equal to -8 (0xFFFFFFF8).
REQ-026 Impulse of 100 at (5,5), all other pixels 0 -> exactly 6 nonzero results: window ending (7,7)=+100, (7,6)=+200, (7,5)=+100, (5,7)=-100, (5,6)=-200, (5,5)=-100; all others 0.
REQ-027 Repeat REQ-025 with rdata_r dropped for 3 cycles in the middle of row 10 and for 1 cycle at the end of each row -> identical 676 values; wdata_r=0 during each stall.
REQ-028 Reset asserted after 400 pixels, then a fresh full frame of all -32768 with kernel all 1 -> 676 results, each -294912.
